// File: rtl/trace_stream_serializer.sv
// Splits 64-bit trace records from a FWFT FIFO into narrow valid/ready beats.
// LSB slice goes first; m_last marks the final beat of each record.
module trace_stream_serializer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic [31:0]          records_sent
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
        $error("IN_WIDTH must be a multiple of OUT_WIDTH");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  sreg_q, sreg_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 is_last;
    logic                 accept;
    logic                 last_acc;
    logic                 load;

    assign is_last      = (beat_q == BEAT_W'(RATIO - 1));
    assign m_valid      = (state_q == SEND);
    assign m_last       = m_valid && is_last;
    assign m_data       = sreg_q[OUT_WIDTH-1:0];
    assign records_sent = cnt_q;
    assign accept       = m_valid && m_ready;
    assign last_acc     = accept && is_last;
    assign load         = rst_n && enable && !fifo_empty
                          && ((state_q == IDLE) || last_acc);
    assign fifo_rd_en   = load;

    // Next-state: advance beats on accept, reload from FIFO on pop
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (is_last) begin
                        cnt_d   = cnt_q + 32'd1;
                        state_d = load ? SEND : IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        sreg_d = sreg_q >> OUT_WIDTH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            sreg_d = fifo_rd_data;
            beat_d = '0;
        end
    end

    // State, shift register, beat index and record counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_trace_stream_serializer.sv
// Scoreboard bench for trace_stream_serializer.
// A queue-based FWFT FIFO model feeds the DUT; a monitor pops expected beats.
module tb_trace_stream_serializer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [31:0] records_sent;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int cyc    = 0;

    logic [63:0] mem [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic [32:0] exp_q[$];
    int          pop_log[$];
    int          beat_log[$];

    trace_stream_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .records_sent (records_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_rd_data = mem[rd_ptr % 16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    // Monitor: compare every accepted beat with the scoreboard head
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            pops++;
            pop_log.push_back(cyc);
        end
        if (rst_n && m_valid && m_ready) begin
            beat_log.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected beat data=%h last=%b",
                         m_data, m_last);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e) begin
                    errors++;
                    $display("FAIL beat: got last=%b data=%h want last=%b data=%h",
                             m_last, m_data, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [63:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr++;
        exp_q.push_back({1'b0, d[31:0]});
        exp_q.push_back({1'b1, d[63:32]});
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            step();
            n++;
        end
        chk(m_valid === 1'b1, name, {63'd0, m_valid}, 64'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !fifo_empty || m_valid) && n < 200) begin
            step();
            n++;
        end
        chk(exp_q.size() == 0, name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;

        // 1: single record pre-loaded during reset
        push_rec(64'h1111_2222_3333_4444);
        step();
        chk(m_valid === 1'b0, "rst_valid", {63'd0, m_valid}, 64'd0);
        chk(m_last === 1'b0, "rst_last", {63'd0, m_last}, 64'd0);
        chk(m_data === 32'd0, "rst_data", {32'd0, m_data}, 64'd0);
        chk(records_sent === 32'd0, "rst_cnt", {32'd0, records_sent}, 64'd0);
        chk(fifo_rd_en === 1'b0, "rst_rden", {63'd0, fifo_rd_en}, 64'd0);
        step();
        rst_n = 1'b1;
        drain("t1_drain");
        chk(records_sent === 32'd1, "t1_cnt", {32'd0, records_sent}, 64'd1);
        chk(pops == 1, "t1_pops", 64'(pops), 64'd1);

        // 2: four back-to-back records, no bubbles
        pop_log.delete();
        beat_log.delete();
        push_rec(64'hA0A0_A0A1_B0B0_B0B1);
        push_rec(64'hA1A1_A1A2_B1B1_B1B2);
        push_rec(64'hA2A2_A2A3_B2B2_B2B3);
        push_rec(64'hA3A3_A3A4_B3B3_B3B4);
        drain("t2_drain");
        chk(records_sent === 32'd5, "t2_cnt", {32'd0, records_sent}, 64'd5);
        chk(pop_log.size() == 4, "t2_npop", 64'(pop_log.size()), 64'd4);
        if (pop_log.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk(pop_log[i] - pop_log[0] == 2 * i, "t2_popgap",
                    64'(pop_log[i] - pop_log[0]), 64'(2 * i));
        end
        chk(beat_log.size() == 8, "t2_nbeat", 64'(beat_log.size()), 64'd8);
        if (beat_log.size() == 8)
            chk(beat_log[7] - beat_log[0] == 7, "t2_bubble",
                64'(beat_log[7] - beat_log[0]), 64'd7);

        // 3: backpressure mid-record with a second record waiting
        m_ready = 1'b0;
        push_rec(64'hAAAA_BBBB_CCCC_DDDD);
        push_rec(64'h5555_6666_7777_8888);
        wait_valid("t3_valid");
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            step();
            chk(m_valid === 1'b1 && m_data === 32'hAAAA_BBBB && m_last === 1'b1,
                "t3_hold", {31'd0, m_valid, m_last, m_data},
                {32'h0000_0003, 32'hAAAA_BBBB});
        end
        chk(pops == p0, "t3_nopop", 64'(pops), 64'(p0));
        m_ready = 1'b1;
        drain("t3_drain");
        chk(records_sent === 32'd7, "t3_cnt", {32'd0, records_sent}, 64'd7);

        // 4: enable dropped after first beat; B must stay queued
        push_rec(64'h0A0A_0A0A_0B0B_0B0B);
        wait_valid("t4_valid");
        step();
        enable = 1'b0;
        push_rec(64'h0C0C_0C0C_0D0D_0D0D);
        p0 = pops;
        for (int i = 0; i < 6; i++) step();
        chk(m_valid === 1'b0, "t4_idle", {63'd0, m_valid}, 64'd0);
        chk(pops == p0, "t4_nopop", 64'(pops), 64'(p0));
        chk(records_sent === 32'd8, "t4_cntA", {32'd0, records_sent}, 64'd8);
        chk(!fifo_empty, "t4_queued", {63'd0, fifo_empty}, 64'd0);
        enable = 1'b1;
        drain("t4_drain");
        chk(records_sent === 32'd9, "t4_cnt", {32'd0, records_sent}, 64'd9);

        // 5: asynchronous reset mid-record
        push_rec(64'hDEAD_BEEF_CAFE_F00D);
        wait_valid("t5_valid");
        step();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk(m_valid === 1'b0, "t5_valid0", {63'd0, m_valid}, 64'd0);
        chk(records_sent === 32'd0, "t5_cnt0", {32'd0, records_sent}, 64'd0);
        push_rec(64'h0123_4567_89AB_CDEF);
        step();
        chk(fifo_rd_en === 1'b0, "t5_rden", {63'd0, fifo_rd_en}, 64'd0);
        step();
        rst_n = 1'b1;
        drain("t5_drain");
        chk(records_sent === 32'd1, "t5_cnt", {32'd0, records_sent}, 64'd1);

        // 6: empty FIFO, then counter wrap
        p0 = pops;
        beat_log.delete();
        for (int i = 0; i < 20; i++) step();
        chk(pops == p0, "t6_nopop", 64'(pops), 64'(p0));
        chk(beat_log.size() == 0, "t6_nobeat", 64'(beat_log.size()), 64'd0);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        step();
        chk(records_sent === 32'hFFFF_FFFF, "t6_pre",
            {32'd0, records_sent}, 64'hFFFF_FFFF);
        push_rec(64'h7777_7777_9999_9999);
        drain("t6_drain");
        chk(records_sent === 32'd0, "t6_wrap", {32'd0, records_sent}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
